// File: rtl/mfp_ahb_ram_arbiter.sv
// mfp_ahb_ram_arbiter
//   Two-master AHB-Lite arbiter in front of a single mfp_ahb_ram_slave.
//   Uncontended address phases are forwarded combinationally, so there are
//   no added wait states. When both masters collide, or the slave is stalled,
//   the address phase that was not issued is captured into a per-master
//   pending slot. That master is then held in its data phase until the
//   transfer is replayed. Ties are broken round-robin.
//
// Ports
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   M0_* / M1_*          AHB-Lite master-side ports (address/control/wdata in;
//                        HRDATA/HREADY/HRESP out)
//   S_*                  AHB-Lite port towards the RAM slave
module mfp_ahb_ram_arbiter (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic [31:0] M0_HADDR,
  input  logic [2:0]  M0_HBURST,
  input  logic [2:0]  M0_HSIZE,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic        M0_HSEL,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,

  input  logic [31:0] M1_HADDR,
  input  logic [2:0]  M1_HBURST,
  input  logic [2:0]  M1_HSIZE,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic        M1_HSEL,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,

  output logic [31:0] S_HADDR,
  output logic [2:0]  S_HBURST,
  output logic [2:0]  S_HSIZE,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic        S_HSEL,
  output logic [31:0] S_HWDATA,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADY,
  input  logic        S_HRESP
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  // Pending address-phase slots, one per master
  logic        pend0_r, pend1_r;
  logic [31:0] pend0_addr_r, pend1_addr_r;
  logic [2:0]  pend0_size_r, pend1_size_r;
  logic        pend0_write_r, pend1_write_r;

  owner_t      dph_owner_r;
  logic        last_grant_r;   // 0 = M0 issued last, 1 = M1 issued last

  logic        req0_s, req1_s;
  logic        cand0_s, cand1_s;
  logic        gnt0_s, gnt1_s;

  // Every beat is reissued as SINGLE, so the masters' burst type is not needed
  logic        unused_burst_s;
  assign unused_burst_s = ^{M0_HBURST, M1_HBURST};

  // A pending slot forces that master's HREADY low. This keeps a live and a
  // pending request from existing at the same time for one master.
  assign M0_HREADY = !pend0_r && ((dph_owner_r != OWN_M0) || S_HREADY);
  assign M1_HREADY = !pend1_r && ((dph_owner_r != OWN_M1) || S_HREADY);

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;

  assign M0_HRESP  = (dph_owner_r == OWN_M0) ? S_HRESP : 1'b0;
  assign M1_HRESP  = (dph_owner_r == OWN_M1) ? S_HRESP : 1'b0;

  assign req0_s  = M0_HSEL && (M0_HTRANS != HTRANS_IDLE) && M0_HREADY;
  assign req1_s  = M1_HSEL && (M1_HTRANS != HTRANS_IDLE) && M1_HREADY;
  assign cand0_s = req0_s || pend0_r;
  assign cand1_s = req1_s || pend1_r;

  // Round-robin grant. Nothing is issued while in reset or while the slave is stalled.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (HRESETn && S_HREADY) begin
      if (cand0_s && cand1_s) begin
        if (last_grant_r) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else if (cand0_s) begin
        gnt0_s = 1'b1;
      end else if (cand1_s) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b0;
      end
    end else begin
      gnt0_s = 1'b0;
    end
  end

  // Slave address phase: from the live inputs if the request is live, otherwise from the pending slot
  always_comb begin
    S_HSEL   = 1'b0;
    S_HTRANS = HTRANS_IDLE;
    S_HBURST = HBURST_SINGLE;
    S_HADDR  = 32'h0000_0000;
    S_HSIZE  = 3'b000;
    S_HWRITE = 1'b0;
    if (gnt0_s) begin
      S_HSEL   = 1'b1;
      S_HTRANS = HTRANS_NONSEQ;
      S_HADDR  = req0_s ? M0_HADDR  : pend0_addr_r;
      S_HSIZE  = req0_s ? M0_HSIZE  : pend0_size_r;
      S_HWRITE = req0_s ? M0_HWRITE : pend0_write_r;
    end else if (gnt1_s) begin
      S_HSEL   = 1'b1;
      S_HTRANS = HTRANS_NONSEQ;
      S_HADDR  = req1_s ? M1_HADDR  : pend1_addr_r;
      S_HSIZE  = req1_s ? M1_HSIZE  : pend1_size_r;
      S_HWRITE = req1_s ? M1_HWRITE : pend1_write_r;
    end else begin
      S_HSEL   = 1'b0;
    end
  end

  // Write data follows the data-phase owner. Stalled masters hold HWDATA, so it is not stored.
  always_comb begin
    S_HWDATA = 32'h0000_0000;
    case (dph_owner_r)
      OWN_M0:  S_HWDATA = M0_HWDATA;
      OWN_M1:  S_HWDATA = M1_HWDATA;
      default: S_HWDATA = 32'h0000_0000;
    endcase
  end

  // Pending capture/release, data-phase ownership and round-robin history
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend0_r       <= 1'b0;
      pend0_addr_r  <= 32'h0000_0000;
      pend0_size_r  <= 3'b000;
      pend0_write_r <= 1'b0;
      pend1_r       <= 1'b0;
      pend1_addr_r  <= 32'h0000_0000;
      pend1_size_r  <= 3'b000;
      pend1_write_r <= 1'b0;
      dph_owner_r   <= OWN_NONE;
      last_grant_r  <= 1'b1;
    end else begin
      if (gnt0_s) begin
        pend0_r <= 1'b0;
      end else if (req0_s) begin
        pend0_r       <= 1'b1;
        pend0_addr_r  <= M0_HADDR;
        pend0_size_r  <= M0_HSIZE;
        pend0_write_r <= M0_HWRITE;
      end

      if (gnt1_s) begin
        pend1_r <= 1'b0;
      end else if (req1_s) begin
        pend1_r       <= 1'b1;
        pend1_addr_r  <= M1_HADDR;
        pend1_size_r  <= M1_HSIZE;
        pend1_write_r <= M1_HWRITE;
      end

      if (S_HREADY) begin
        if (gnt0_s) begin
          dph_owner_r <= OWN_M0;
        end else if (gnt1_s) begin
          dph_owner_r <= OWN_M1;
        end else begin
          dph_owner_r <= OWN_NONE;
        end
      end

      if (gnt0_s || gnt1_s) begin
        last_grant_r <= gnt1_s;
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_ram_arbiter.sv
// Directed testbench for mfp_ahb_ram_arbiter with a small behavioural RAM
// slave (byte/halfword/word lanes, stall injection, per-word write counters).
module tb_mfp_ahb_ram_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic [2:0]  M0_HBURST, M1_HBURST, M0_HSIZE, M1_HSIZE;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, M0_HSEL, M1_HSEL;
  logic [31:0] M0_HWDATA, M1_HWDATA, M0_HRDATA, M1_HRDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [2:0]  S_HBURST, S_HSIZE;
  logic [1:0]  S_HTRANS;
  logic        S_HWRITE, S_HSEL, S_HREADY, S_HRESP;

  int n_assert = 0;
  int n_fail   = 0;

  mfp_ahb_ram_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(M0_HADDR), .M0_HBURST(M0_HBURST), .M0_HSIZE(M0_HSIZE),
    .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSEL(M0_HSEL),
    .M0_HWDATA(M0_HWDATA), .M0_HRDATA(M0_HRDATA), .M0_HREADY(M0_HREADY),
    .M0_HRESP(M0_HRESP),
    .M1_HADDR(M1_HADDR), .M1_HBURST(M1_HBURST), .M1_HSIZE(M1_HSIZE),
    .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSEL(M1_HSEL),
    .M1_HWDATA(M1_HWDATA), .M1_HRDATA(M1_HRDATA), .M1_HREADY(M1_HREADY),
    .M1_HRESP(M1_HRESP),
    .S_HADDR(S_HADDR), .S_HBURST(S_HBURST), .S_HSIZE(S_HSIZE),
    .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSEL(S_HSEL),
    .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY),
    .S_HRESP(S_HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- behavioural RAM slave ----------------
  logic [31:0] mem [0:63];
  int          wr_cnt [0:63];
  logic        dp_valid, dp_write, stall;
  logic [31:0] dp_addr;
  logic [2:0]  dp_size;

  assign S_HREADY = !stall;
  assign S_HRESP  = 1'b0;
  assign S_HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[7:2]] : 32'h0000_0000;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] a, input logic [2:0] sz);
    logic [31:0] m;
    case (sz)
      3'd0:    m = 32'h0000_00FF << {a, 3'b000};
      3'd1:    m = 32'h0000_FFFF << {a[1], 4'b0000};
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | (wd & m);
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 32'h0;
      dp_size  <= 3'd0;
      for (int i = 0; i < 64; i++) begin
        mem[i]    <= 32'h0;
        wr_cnt[i] <= 0;
      end
    end else if (S_HREADY) begin
      if (dp_valid && dp_write) begin
        mem[dp_addr[7:2]]    <= merge(mem[dp_addr[7:2]], S_HWDATA, dp_addr[1:0], dp_size);
        wr_cnt[dp_addr[7:2]] <= wr_cnt[dp_addr[7:2]] + 1;
      end
      dp_valid <= S_HSEL && S_HTRANS[1];
      dp_write <= S_HWRITE;
      dp_addr  <= S_HADDR;
      dp_size  <= S_HSIZE;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic m0_drv(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] sz, input logic [2:0] bu);
    M0_HSEL = sel; M0_HTRANS = tr; M0_HADDR = a; M0_HWRITE = wr; M0_HSIZE = sz; M0_HBURST = bu;
  endtask

  task automatic m1_drv(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                        input logic wr, input logic [2:0] sz, input logic [2:0] bu);
    M1_HSEL = sel; M1_HTRANS = tr; M1_HADDR = a; M1_HWRITE = wr; M1_HSIZE = sz; M1_HBURST = bu;
  endtask

  task automatic all_idle();
    m0_drv(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0);
    m1_drv(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    stall = 1'b0;
    M0_HWDATA = 32'h0; M1_HWDATA = 32'h0;
    all_idle();
    HRESETn = 1'b0;

    // Reset: a live M0 request must not reach the slave
    m0_drv(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 3'd0);
    #2;
    chk("rst_m0_hready", {31'd0, M0_HREADY}, 32'd1);
    chk("rst_m1_hready", {31'd0, M1_HREADY}, 32'd1);
    chk("rst_s_hsel",    {31'd0, S_HSEL},    32'd0);
    chk("rst_s_htrans",  {30'd0, S_HTRANS},  32'd0);
    chk("rst_s_haddr",   S_HADDR,            32'h0);
    chk("rst_m0_hresp",  {31'd0, M0_HRESP},  32'd0);
    chk("rst_hrdata",    M1_HRDATA,          S_HRDATA);
    tick(); tick();
    HRESETn = 1'b1;
    all_idle();
    tick();

    // Solo write then read by M0
    m0_drv(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 3'd0);
    #2;
    chk("solo_wr_htrans", {30'd0, S_HTRANS}, 32'd2);
    chk("solo_wr_haddr",  S_HADDR,           32'h10);
    chk("solo_wr_hready", {31'd0, M0_HREADY}, 32'd1);
    tick();
    m0_drv(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 3'd0);
    M0_HWDATA = 32'hDEAD_BEEF;
    #2;
    chk("solo_rd_htrans", {30'd0, S_HTRANS}, 32'd2);
    chk("solo_wdata",     S_HWDATA,          32'hDEAD_BEEF);
    chk("solo_rd_hready", {31'd0, M0_HREADY}, 32'd1);
    tick();
    all_idle();
    #2;
    chk("solo_rdata",     M0_HRDATA,         32'hDEAD_BEEF);
    chk("solo_dp_hready", {31'd0, M0_HREADY}, 32'd1);
    tick();

    // Collision right after reset: M0 wins, M1 replayed next cycle
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    m0_drv(1'b1, 2'b10, 32'h0, 1'b1, 3'd2, 3'd0);
    m1_drv(1'b1, 2'b10, 32'h4, 1'b1, 3'd2, 3'd0);
    #2;
    chk("col_first_addr", S_HADDR, 32'h0);
    chk("col_t0_m1_rdy",  {31'd0, M1_HREADY}, 32'd1);
    tick();
    all_idle();
    M0_HWDATA = 32'h1111_1111;
    M1_HWDATA = 32'h2222_2222;
    #2;
    chk("col_second_addr", S_HADDR, 32'h4);
    chk("col_second_wr",   {31'd0, S_HWRITE}, 32'd1);
    chk("col_t1_m1_rdy",   {31'd0, M1_HREADY}, 32'd0);
    chk("col_t1_m0_rdy",   {31'd0, M0_HREADY}, 32'd1);
    chk("col_t1_wdata",    S_HWDATA, 32'h1111_1111);
    tick();
    #2;
    chk("col_t2_m1_rdy",   {31'd0, M1_HREADY}, 32'd1);
    chk("col_t2_wdata",    S_HWDATA, 32'h2222_2222);
    tick();
    m0_drv(1'b1, 2'b10, 32'h0, 1'b0, 3'd2, 3'd0);
    tick();
    all_idle();
    m1_drv(1'b1, 2'b10, 32'h4, 1'b0, 3'd2, 3'd0);
    #2;
    chk("col_rd_m0", M0_HRDATA, 32'h1111_1111);
    tick();
    all_idle();
    #2;
    chk("col_rd_m1", M1_HRDATA, 32'h2222_2222);
    tick();

    // Round robin: both masters read continuously, issue must alternate M0, M1
    m0_drv(1'b1, 2'b10, 32'h0, 1'b0, 3'd2, 3'd0);
    m1_drv(1'b1, 2'b10, 32'h4, 1'b0, 3'd2, 3'd0);
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("rr_issue_addr", S_HADDR, (i % 2 == 0) ? 32'h0 : 32'h4);
      if (i == 1) chk("rr_m0_rdata", M0_HRDATA, 32'h1111_1111);
      if (i == 2) chk("rr_m1_rdata", M1_HRDATA, 32'h2222_2222);
      tick();
    end
    all_idle();
    tick(); tick(); tick();

    // Byte INCR4 burst from M1: each beat reissued as NONSEQ SINGLE byte
    M1_HWDATA = 32'hAAAA_AAAA;
    for (int b = 0; b < 4; b++) begin
      m1_drv(1'b1, (b == 0) ? 2'b10 : 2'b11, 32'h21 + 32'(b), 1'b1, 3'd0, 3'b011);
      #2;
      chk("burst_hburst", {29'd0, S_HBURST}, 32'd0);
      chk("burst_hsize",  {29'd0, S_HSIZE},  32'd0);
      chk("burst_htrans", {30'd0, S_HTRANS}, 32'd2);
      chk("burst_haddr",  S_HADDR, 32'h21 + 32'(b));
      tick();
    end
    m1_drv(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 3'd0);
    tick();
    all_idle();
    #2;
    chk("burst_word20", M1_HRDATA, 32'hAAAA_AA00);
    tick();
    chk("burst_word24", mem[9], 32'h0000_00AA);

    // Slave stall with both masters requesting
    m0_drv(1'b1, 2'b10, 32'h30, 1'b1, 3'd2, 3'd0);
    m1_drv(1'b1, 2'b10, 32'h34, 1'b1, 3'd2, 3'd0);
    tick();
    all_idle();
    M0_HWDATA = 32'h3030_3030;
    M1_HWDATA = 32'h3434_3434;
    stall = 1'b1;
    for (int s = 0; s < 2; s++) begin
      #2;
      chk("stall_m0_rdy", {31'd0, M0_HREADY}, 32'd0);
      chk("stall_m1_rdy", {31'd0, M1_HREADY}, 32'd0);
      chk("stall_no_sel", {31'd0, S_HSEL},    32'd0);
      tick();
    end
    stall = 1'b0;
    #2;
    chk("stall_rel_addr",  S_HADDR, 32'h34);
    chk("stall_rel_wdata", S_HWDATA, 32'h3030_3030);
    chk("stall_rel_m0rdy", {31'd0, M0_HREADY}, 32'd1);
    chk("stall_rel_m1rdy", {31'd0, M1_HREADY}, 32'd0);
    tick();
    #2;
    chk("stall_m1_done", {31'd0, M1_HREADY}, 32'd1);
    chk("stall_m1_wdata", S_HWDATA, 32'h3434_3434);
    tick();
    tick();
    chk("stall_mem30", mem[12], 32'h3030_3030);
    chk("stall_mem34", mem[13], 32'h3434_3434);
    chk("stall_cnt30", 32'(wr_cnt[12]), 32'd1);
    chk("stall_cnt34", 32'(wr_cnt[13]), 32'd1);

    // Reset asserted while M1 is pending
    m0_drv(1'b1, 2'b10, 32'h38, 1'b1, 3'd2, 3'd0);
    m1_drv(1'b1, 2'b10, 32'h3C, 1'b1, 3'd2, 3'd0);
    tick();
    m0_drv(1'b1, 2'b10, 32'h40, 1'b1, 3'd2, 3'd0);
    m1_drv(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 3'd0);
    M0_HWDATA = 32'h3838_3838;
    M1_HWDATA = 32'h3C3C_3C3C;
    #2;
    chk("rst_mid_pend", {31'd0, M1_HREADY}, 32'd0);
    #1;
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_m1rdy",  {31'd0, M1_HREADY}, 32'd1);
    chk("rst_mid_m0rdy",  {31'd0, M0_HREADY}, 32'd1);
    chk("rst_mid_hsel",   {31'd0, S_HSEL},    32'd0);
    chk("rst_mid_htrans", {30'd0, S_HTRANS},  32'd0);
    chk("rst_mid_haddr",  S_HADDR,            32'h0);
    chk("rst_mid_wdata",  S_HWDATA,           32'h0);
    all_idle();
    tick(); tick();
    HRESETn = 1'b1;
    tick(); tick(); tick();
    chk("rst_mid_no_wr3c", 32'(wr_cnt[15]), 32'd0);
    chk("rst_mid_mem3c",   mem[15], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_ram_arbiter.md
# mfp_ahb_ram_arbiter

Two-master AHB-Lite arbiter that shares one `mfp_ahb_ram_slave` between two requesters, for example the MIPS core bus and a DMA or debug master. It sits between the two master ports and the single RAM slave port. Uncontended transfers pass through with zero added wait states. In a collision, the arbiter accepts and registers the losing address phase, stalls that master in its data phase, and replays the transfer on the next free slave address slot. Arbitration is round-robin.

## Interface
Parameters:
- none

Ports (Mn = M0 or M1, one set each):
- HCLK  in  1  bus clock; all state on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- Mn_HADDR  in  32  master address
- Mn_HBURST  in  3  master burst type
- Mn_HSIZE  in  3  master transfer size
- Mn_HTRANS  in  2  master transfer type
- Mn_HWRITE  in  1  master write flag
- Mn_HSEL  in  1  master selects RAM
- Mn_HWDATA  in  32  master write data
- Mn_HRDATA  out  32  read data (S_HRDATA broadcast)
- Mn_HREADY  out  1  transfer-done / stall to master
- Mn_HRESP  out  1  response to master
- S_HADDR  out  32  slave address
- S_HBURST  out  3  slave burst type
- S_HSIZE  out  3  slave transfer size
- S_HTRANS  out  2  slave transfer type
- S_HWRITE  out  1  slave write flag
- S_HSEL  out  1  slave select
- S_HWDATA  out  32  slave write data
- S_HRDATA  in  32  slave read data
- S_HREADY  in  1  slave ready
- S_HRESP  in  1  slave response

## Operation
- Request definitions:
  - req_n (live) = Mn_HSEL && Mn_HTRANS != IDLE && Mn_HREADY.
  - cand_n = req_n || pend_n.
  - A master never has both a live and a pending request, because pend_n forces Mn_HREADY low.
- State:
  - pend_n: valid flag plus captured HADDR/HSIZE/HWRITE per master.
  - dph_owner ∈ {NONE, M0, M1}: owner of the current slave data phase.
  - last_grant: 1 bit, the last master issued.
- Issue:
  - When S_HREADY = 1 and any cand_n is set, exactly one master is granted.
  - If only one master is a candidate, that master is granted.
  - If both are candidates, the master != last_grant is granted.
- Slave address phase for the granted master:
  - S_HSEL = 1, S_HTRANS = NONSEQ, S_HBURST = SINGLE.
  - S_HADDR, S_HSIZE and S_HWRITE come from the live inputs if req_n, otherwise from pend_n.
  - SEQ transfers are always reissued as NONSEQ SINGLE, so the slave's byte/halfword masks stay correct.
- No grant: S_HSEL = 0, S_HTRANS = IDLE; S_HADDR, S_HSIZE, S_HWRITE = 0.
- Capture: if req_n is set but n is not granted (other master won, or S_HREADY = 0), pend_n is set on the clock edge.
- Release:
  - pend_n clears when n is granted.
  - dph_owner takes the granted master (or NONE) on each edge where S_HREADY = 1.
  - dph_owner holds on edges where S_HREADY = 0.
- Data phase:
  - S_HWDATA = Mn_HWDATA of dph_owner, or 0 if NONE. The master holds HWDATA stable while stalled, so write data is not captured.
  - Mn_HREADY = !pend_n && (dph_owner != n || S_HREADY).
  - Mn_HRESP = (dph_owner == n) ? S_HRESP : 0.
- HMASTLOCK and HPROT are not supported. Locked sequences from one master can be interleaved with the other master.

## Timing
- Reset (asynchronous assert, synchronous-to-HCLK release):
  - pend_0 = pend_1 = 0, dph_owner = NONE, last_grant = 1, so M0 wins the first tie.
  - Outputs during reset: Mn_HREADY = 1, Mn_HRESP = 0, Mn_HRDATA = S_HRDATA, S_HSEL = 0, S_HTRANS = IDLE, all other S_* = 0.
  - Reset asserted mid-transfer discards pending requests with no slave access issued.
- Uncontended latency: 0 added cycles. The address phase is forwarded combinationally; the data phase completes in the next cycle with S_HREADY.
- Collision in cycle t:
  - Winner is issued at t.
  - Loser is captured at t and issued at t+1 if S_HREADY = 1.
  - Loser's Mn_HREADY is 0 at t+1 and follows S_HREADY at t+2.
- Sustained contention: grants strictly alternate. Each master then gets one transfer every 2 cycles, with worst-case wait 1 cycle per transfer at zero-wait slave.
- S_HREADY low: no new issue, dph_owner holds, new live requests are captured. At most one pending per master, so no transfer is lost.

## Test plan
- Solo access: M0 writes 0xDEADBEEF to 0x10 (word), then reads 0x10 → M0_HREADY stays 1; M0_HRDATA = 0xDEADBEEF in the read data phase; S_HTRANS = NONSEQ in both address phases.
- Collision right after reset: M0 writes 0x11111111 to 0x0 and M1 writes 0x22222222 to 0x4 in the same cycle →
  - M0 is issued first; S_HADDR = 0x4 in the next cycle.
  - M1_HREADY is low for exactly 1 cycle.
  - Readback gives both values.
- Round-robin: both masters issue back-to-back word reads for 8 cycles → slave issue order is M0, M1, M0, M1, …; no master starves.
- Byte write in a burst: M1 issues an INCR4 byte burst writing 0xAA to 0x21..0x24 →
  - S_HBURST = SINGLE and S_HSIZE = byte on every issued beat.
  - Word 0x20 reads 0xAAAAAA00 when its prior contents were 0x00000000.
- Slave stall: model holds S_HREADY low 2 cycles while both masters request → both Mn_HREADY go low; after release, both transfers complete with correct data and none is duplicated.
- Reset mid-operation: HRESETn is pulled low asynchronously while M1 is pending →
  - Outputs take reset values without waiting for an HCLK edge.
  - No slave write to M1's address occurs after release.
